// File: rtl/vga_timing_gen.sv
// VGA raster timing: column/row counters, registered syncs, video-on and frame-start.
// Define VGA_CLKDIV2_EN to derive the pixel tick as Clock/2 (toggling phase flop).
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       Clock,
    input  logic       Reset,
    output logic       oPixelTick,
    output logic [9:0] oCol,
    output logic [9:0] oRow,
    output logic       oHSync,
    output logic       oVSync,
    output logic       oVideoOn,
    output logic       oFrameStart
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);

    logic       tick_q, tick_d;
    logic [9:0] col_q, col_d;
    logic [9:0] row_q, row_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       video_on_q, video_on_d;
    logic       frame_start_q, frame_start_d;

    always_comb begin
`ifdef VGA_CLKDIV2_EN
        tick_d = ~tick_q;
`else
        tick_d = 1'b1;
`endif
        col_d = col_q;
        row_d = row_q;
        if (tick_q) begin
            if (col_q == H_LAST) begin
                col_d = '0;
                row_d = (row_q == V_LAST) ? '0 : row_q + 10'd1;
            end else begin
                col_d = col_q + 10'd1;
            end
        end
        // Decoded from the next position so flags line up with the counters.
        hsync_d       = (col_d >= HS_FIRST && col_d <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
        vsync_d       = (row_d >= VS_FIRST && row_d <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
        video_on_d    = (col_d < H_VIS) && (row_d < V_VIS);
        frame_start_d = tick_q && (col_d == '0) && (row_d == '0);
    end

    // Reset parks the raster at the last blanking position of the frame.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            tick_q        <= 1'b0;
            col_q         <= H_LAST;
            row_q         <= V_LAST;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            tick_q        <= tick_d;
            col_q         <= col_d;
            row_q         <= row_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign oPixelTick  = tick_q;
    assign oCol        = col_q;
    assign oRow        = row_q;
    assign oHSync      = hsync_q;
    assign oVSync      = vsync_q;
    assign oVideoOn    = video_on_q;
    assign oFrameStart = frame_start_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: default-timing DUT plus a shrunken active-high-sync DUT,
// both checked every cycle against a linear-position reference model.
module tb_vga_timing_gen;
    typedef struct packed {
        logic       tick;
        logic [9:0] col;
        logic [9:0] row;
        logic       hs;
        logic       vs;
        logic       von;
        logic       fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       t0, hs0, vs0, von0, fs0, t1, hs1, vs1, von1, fs1;
    logic [9:0] c0, r0, c1, r1;

    vga_timing_gen u_dut0 (
        .Clock(clk), .Reset(rst_n), .oPixelTick(t0), .oCol(c0), .oRow(r0),
        .oHSync(hs0), .oVSync(vs0), .oVideoOn(von0), .oFrameStart(fs0)
    );

    vga_timing_gen #(
        .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(5),
        .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1)
    ) u_dut1 (
        .Clock(clk), .Reset(rst_n), .oPixelTick(t1), .oCol(c1), .oRow(r1),
        .oHSync(hs1), .oVSync(vs1), .oVideoOn(von1), .oFrameStart(fs1)
    );

    exp_t q0[$], q1[$];
    int   checks = 0;
    int   errors = 0;

    // Position after n ticks is a linear index into the frame, starting one
    // pixel before (0,0).
    function automatic exp_t ref_out(longint n, bit tick, bit adv, int ha, int hf, int hs,
                                     int hb, int va, int vf, int vs, int vb, bit pol);
        int     ht = ha + hf + hs + hb;
        int     vt = va + vf + vs + vb;
        longint ft = longint'(ht) * vt;
        longint p  = (ft - 1 + n) % ft;
        int     col = int'(p % ht);
        int     row = int'(p / ht);
        exp_t   e;
        e.tick = tick;
        e.col  = 10'(col);
        e.row  = 10'(row);
        e.hs   = (col >= ha + hf && col < ha + hf + hs) ? pol : !pol;
        e.vs   = (row >= va + vf && row < va + vf + vs) ? pol : !pol;
        e.von  = (col < ha) && (row < va);
        e.fs   = adv && (p == 0);
        return e;
    endfunction

    longint n = 0;
    bit     tick = 1'b0;
    bit     adv = 1'b0;

    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            n = 0; tick = 1'b0; adv = 1'b0;
        end else begin
            adv = tick;
            if (adv) n++;
`ifdef VGA_CLKDIV2_EN
            tick = !tick;
`else
            tick = 1'b1;
`endif
        end
        q0.push_back(ref_out(n, tick, adv, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
        q1.push_back(ref_out(n, tick, adv, 20, 2, 3, 5, 10, 1, 2, 3, 1'b1));
        #1;
    endtask

    task automatic run(int cycles, bit r);
        for (int i = 0; i < cycles; i++) begin
            rst_n = r;
            step();
        end
    endtask

    task automatic compare(string name, exp_t got, exp_t e);
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s t=%0t got tick=%b col=%0d row=%0d hs=%b vs=%b von=%b fs=%b exp tick=%b col=%0d row=%0d hs=%b vs=%b von=%b fs=%b",
                     name, $time, got.tick, got.col, got.row, got.hs, got.vs, got.von, got.fs,
                     e.tick, e.col, e.row, e.hs, e.vs, e.von, e.fs);
        end
    endtask

    always @(negedge clk) begin
        if (q0.size() > 0) compare("dut0", {t0, c0, r0, hs0, vs0, von0, fs0}, q0.pop_front());
        if (q1.size() > 0) compare("dut1", {t1, c1, r1, hs1, vs1, von1, fs1}, q1.pop_front());
    end

    initial begin
        run(4, 1'b0);
        run(2600, 1'b1);          // three full default lines
        run($urandom_range(1, 3), 1'b0);
        run(1200, 1'b1);          // several small frames after restart
        for (int k = 0; k < 25; k++) begin
            run($urandom_range(50, 1500), 1'b1);
            run($urandom_range(1, 3), 1'b0);
        end
        run(500, 1'b1);
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d/%0d pending exp 0/0", q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
